// File: rtl/buffered_spi_responder_pkg.sv
// Shared definitions for the buffered SPI responder: status bit positions,
// synchroniser depth and FIFO pointer sizing.
package buffered_spi_responder_pkg;

    localparam int RX_OVERRUN  = 0;
    localparam int TX_UNDERRUN = 1;
    localparam int FRAME_ERR   = 2;

    localparam int SYNC_STAGES = 2;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffered_spi_responder_sync.sv
// Synchronous FIFO with first-word-fall-through read data; used for both
// the RX and TX queues of the SPI responder.
module sync_fifo
    import buffered_spi_responder_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PW = ptrWidth(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic              w_wrEn;
    logic              w_rdEn;

    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[PW-1] != r_rdPtr[PW-1]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_data  = r_mem[r_rdPtr[AW-1:0]];

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_rdEn = i_pop && !o_empty;
    assign w_wrEn = i_push && (!o_full || w_rdEn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_rdEn) r_rdPtr <= r_rdPtr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/buffered_spi_responder.sv
// Mode-0 SPI responder oversampled in the system clock domain, with RX and
// TX word FIFOs and sticky error flags.
module buffered_spi_responder
    import buffered_spi_responder_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] IDLE_WORD  = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    input  logic              spi_sync,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [2:0]        status,
    input  logic              status_clr
);

    localparam int            CW        = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] WORD_BITS = CW'(DATA_W);

    logic [SYNC_STAGES:0]   r_clkPipe;
    logic [SYNC_STAGES:0]   r_csPipe;
    logic [SYNC_STAGES-1:0] r_mosiPipe;
    logic [SYNC_STAGES-1:0] r_syncPipe;

    logic [CW-1:0]     r_bitCnt;
    logic [DATA_W-1:0] r_rxShift;
    logic [DATA_W-1:0] r_rxWord;
    logic              r_rxPush;
    logic              r_armed;
    logic [DATA_W-1:0] r_txShift;
    logic              r_miso;
    logic [2:0]        r_status;

    logic w_clkRise, w_clkFall, w_csSel, w_csFall, w_csRise, w_mosi, w_sync;
    logic w_bitEn, w_resync, w_wordDone, w_txLoad, w_txPop, w_rxPop;
    logic w_rxFull, w_rxEmpty, w_txFull, w_txEmpty;
    logic [DATA_W-1:0] w_rxHead, w_txHead, w_txWord;
    logic [2:0] w_statusSet;

    // The cs pipe resets to "selected" so that a frame already in progress at
    // reset release is ignored until the next cs fall or sync marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkPipe  <= '0;
            r_csPipe   <= '0;
            r_mosiPipe <= '0;
            r_syncPipe <= '0;
        end else begin
            r_clkPipe  <= {r_clkPipe[SYNC_STAGES-1:0], spi_clk};
            r_csPipe   <= {r_csPipe[SYNC_STAGES-1:0], spi_cs};
            r_mosiPipe <= {r_mosiPipe[SYNC_STAGES-2:0], spi_mosi};
            r_syncPipe <= {r_syncPipe[SYNC_STAGES-2:0], spi_sync};
        end
    end

    assign w_clkRise  = r_clkPipe[SYNC_STAGES-1] && !r_clkPipe[SYNC_STAGES];
    assign w_clkFall  = !r_clkPipe[SYNC_STAGES-1] && r_clkPipe[SYNC_STAGES];
    assign w_csSel    = !r_csPipe[SYNC_STAGES-1];
    assign w_csFall   = w_csSel && r_csPipe[SYNC_STAGES];
    assign w_csRise   = !w_csSel && !r_csPipe[SYNC_STAGES];
    assign w_mosi     = r_mosiPipe[SYNC_STAGES-1];
    assign w_sync     = r_syncPipe[SYNC_STAGES-1];

    assign w_bitEn    = w_csSel && w_clkRise && (r_armed || w_sync);
    assign w_resync   = w_bitEn && w_sync && (r_bitCnt != '0);
    assign w_wordDone = (r_bitCnt == WORD_BITS);

    // A completed word spends one cycle at WORD_BITS before being queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitCnt  <= '0;
            r_rxShift <= '0;
            r_rxWord  <= '0;
            r_rxPush  <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_rxPush <= w_wordDone;
            if (w_wordDone) r_rxWord <= r_rxShift;
            if (!w_csSel) begin
                r_bitCnt <= '0;
                r_armed  <= 1'b0;
            end else if (w_bitEn) begin
                r_armed <= 1'b1;
                if (w_resync) begin
                    r_rxShift <= {{(DATA_W-1){1'b0}}, w_mosi};
                    r_bitCnt  <= CW'(1);
                end else begin
                    r_rxShift <= {r_rxShift[DATA_W-2:0], w_mosi};
                    r_bitCnt  <= r_bitCnt + CW'(1);
                end
            end else begin
                if (w_csFall)   r_armed  <= 1'b1;
                if (w_wordDone) r_bitCnt <= '0;
            end
        end
    end

    assign w_txLoad = w_csFall || (w_csSel && w_clkFall && r_armed && (r_bitCnt == '0));
    assign w_txPop  = w_txLoad && !w_txEmpty;
    assign w_txWord = w_txEmpty ? IDLE_WORD : w_txHead;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_txShift <= '0;
            r_miso    <= 1'b0;
        end else if (!w_csSel) begin
            r_miso <= 1'b0;
        end else if (w_txLoad) begin
            r_txShift <= w_txWord;
            r_miso    <= w_txWord[DATA_W-1];
        end else if (w_clkFall && r_armed) begin
            r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
            r_miso    <= r_txShift[DATA_W-2];
        end
    end

    assign w_rxPop = rx_valid && rx_ready;

    always_comb begin
        w_statusSet              = '0;
        w_statusSet[RX_OVERRUN]  = r_rxPush && w_rxFull && !w_rxPop;
        w_statusSet[TX_UNDERRUN] = w_txLoad && w_txEmpty;
        w_statusSet[FRAME_ERR]   = w_resync ||
                                   (w_csRise && (r_bitCnt != '0) && !w_wordDone);
    end

    // A flag raised in the same cycle as a clear request survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_status <= '0;
        else       r_status <= w_statusSet | (status_clr ? 3'b000 : r_status);
    end

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_rxPush),
        .i_data  (r_rxWord),
        .i_pop   (w_rxPop),
        .o_data  (w_rxHead),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_valid && tx_ready),
        .i_data  (tx_data),
        .i_pop   (w_txPop),
        .o_data  (w_txHead),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty)
    );

    assign spi_miso = r_miso;
    assign rx_valid = !w_rxEmpty;
    assign rx_data  = w_rxEmpty ? '0 : w_rxHead;
    assign tx_ready = !w_txFull;
    assign status   = r_status;

endmodule

// File: tb/tb_buffered_spi_responder.sv
// Bench for buffered_spi_responder: an SPI master model at clk/8 with an RX
// scoreboard, a table of single-word frames and hand-written corner cases.
module tb_buffered_spi_responder;

    logic       clk = 1'b0;
    logic       reset, spi_clk, spi_cs, spi_mosi, spi_sync, spi_miso;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, status_clr;
    logic [2:0] status;

    int         checkCount = 0;
    int         failCount  = 0;
    logic [7:0] expRx[$];
    logic [7:0] expWord, cap, cap2, w;

    typedef struct {
        logic [7:0] mosiWord;
        logic [7:0] txWord;
        bit         preload;
        logic [7:0] expMiso;
        logic [2:0] expStatus;
    } vec_t;

    vec_t vecs[5];

    buffered_spi_responder #(.DATA_W(8), .FIFO_DEPTH(16), .IDLE_WORD(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_sync   (spi_sync),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .status     (status),
        .status_clr (status_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every word the consumer takes must be the oldest word still expected.
    always @(negedge clk) begin
        if (!reset && rx_valid && rx_ready) begin
            if (expRx.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL rxUnexpected: got 0x%0h, expected no word", rx_data);
            end else begin
                expWord = expRx.pop_front();
                checkOutput("rxWord", {24'd0, rx_data}, {24'd0, expWord});
            end
        end
    end

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushTx(input logic [7:0] word);
        @(negedge clk);
        tx_data  = word;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic setRxReady(input logic v);
        @(posedge clk);
        #2 rx_ready = v;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        checkOutput("statusAfterClear", {29'd0, status}, 32'd0);
    endtask

    // Half SPI period is 4 clk; the last fall optionally coincides with cs rising.
    task automatic spiBits(input logic [7:0] word, input int n, input bit syncFirst,
                           input bit endCs, input bit checkLat, output logic [7:0] captured);
        captured = '0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = word[7-i];
            spi_sync = syncFirst && (i == 0);
            waitNeg(4);
            captured = {captured[6:0], spi_miso};
            spi_clk  = 1'b1;
            waitNeg(4);
            if (checkLat && i == n - 1)
                checkOutput("rxValidBeforeLatency", {31'd0, rx_valid}, 32'd0);
            spi_clk = 1'b0;
            if (endCs && i == n - 1) spi_cs = 1'b1;
        end
        spi_sync = 1'b0;
        if (checkLat) begin
            waitNeg(1);
            checkOutput("rxValidAtLatency", {31'd0, rx_valid}, 32'd1);
        end
    endtask

    task automatic csLow();
        @(negedge clk);
        spi_cs = 1'b0;
        waitNeg(6);
    endtask

    task automatic sendFrame(input logic [7:0] word, input bit checkLat,
                             output logic [7:0] captured);
        expRx.push_back(word);
        csLow();
        spiBits(word, 8, 1'b1, 1'b1, checkLat, captured);
        waitNeg(8);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((expRx.size() != 0 || rx_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, expRx.size(), 32'd0);
        checkOutput({name, "Valid"}, {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [7:0] captured);
        if (v.preload) pushTx(v.txWord);
        sendFrame(v.mosiWord, 1'b0, captured);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'h3C, 3'b000};
        vecs[1] = '{8'h5A, 8'h81, 1'b1, 8'h81, 3'b000};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'hFF, 3'b010};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'h00, 3'b000};
        vecs[4] = '{8'hC3, 8'h00, 1'b0, 8'hFF, 3'b010};

        reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_sync = 1'b0;
        rx_ready = 1'b1; tx_data = '0; tx_valid = 1'b0; status_clr = 1'b0;
        waitNeg(3);
        checkOutput("resetMiso", {31'd0, spi_miso}, 32'd0);
        checkOutput("resetRxValid", {31'd0, rx_valid}, 32'd0);
        checkOutput("resetRxData", {24'd0, rx_data}, 32'd0);
        checkOutput("resetTxReady", {31'd0, tx_ready}, 32'd1);
        checkOutput("resetStatus", {29'd0, status}, 32'd0);
        reset = 1'b0;
        waitNeg(4);

        $display("[TB] single word with rx_valid latency");
        pushTx(8'h96);
        sendFrame(8'hA5, 1'b1, cap);
        checkOutput("latencyMiso", {24'd0, cap}, 32'h96);
        checkOutput("latencyStatus", {29'd0, status}, 32'd0);
        drain("latencyDrain");

        $display("[TB] table of single-word frames");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], cap);
            checkOutput($sformatf("vec%0dMiso", i), {24'd0, cap}, {24'd0, vecs[i].expMiso});
            checkOutput($sformatf("vec%0dStatus", i), {29'd0, status}, {29'd0, vecs[i].expStatus});
            pulseClear();
        end
        drain("tableDrain");

        $display("[TB] two preloaded words in one frame");
        pushTx(8'h3C);
        pushTx(8'h81);
        expRx.push_back(8'h11);
        expRx.push_back(8'h22);
        csLow();
        spiBits(8'h11, 8, 1'b1, 1'b0, 1'b0, cap);
        spiBits(8'h22, 8, 1'b1, 1'b1, 1'b0, cap2);
        waitNeg(8);
        checkOutput("twoWordMiso0", {24'd0, cap}, 32'h3C);
        checkOutput("twoWordMiso1", {24'd0, cap2}, 32'h81);
        checkOutput("twoWordStatus", {29'd0, status}, 32'd0);
        drain("twoWordDrain");

        $display("[TB] RX overrun with 17 words");
        setRxReady(1'b0);
        csLow();
        for (int k = 0; k < 17; k++) begin
            w = 8'(k * 13 + 7);
            if (k < 16) expRx.push_back(w);
            spiBits(w, 8, 1'b1, (k == 16), 1'b0, cap);
        end
        waitNeg(8);
        checkOutput("overrunStatus", {29'd0, status}, 32'b011);
        checkOutput("overrunRxValid", {31'd0, rx_valid}, 32'd1);
        setRxReady(1'b1);
        drain("overrunDrain");
        pulseClear();

        $display("[TB] sync marker mid-word");
        pushTx(8'h44);
        expRx.push_back(8'h5A);
        csLow();
        spiBits(8'hF0, 4, 1'b0, 1'b0, 1'b0, cap);
        spiBits(8'h5A, 8, 1'b1, 1'b1, 1'b0, cap);
        waitNeg(8);
        checkOutput("frameErrStatus", {29'd0, status}, 32'b100);
        drain("frameErrDrain");
        pulseClear();

        $display("[TB] TX FIFO full");
        for (int k = 0; k < 16; k++) pushTx(8'(8'h30 + k));
        waitNeg(1);
        checkOutput("txFullReady", {31'd0, tx_ready}, 32'd0);
        pushTx(8'hEE);
        sendFrame(8'h61, 1'b0, cap);
        checkOutput("txFullHead", {24'd0, cap}, 32'h30);
        checkOutput("txFullReadyAfterPop", {31'd0, tx_ready}, 32'd1);
        drain("txFullDrain");

        $display("[TB] reset in the middle of a word");
        csLow();
        spiBits(8'hE5, 3, 1'b1, 1'b0, 1'b0, cap);
        @(negedge clk);
        reset = 1'b1;
        waitNeg(2);
        checkOutput("midResetMiso", {31'd0, spi_miso}, 32'd0);
        checkOutput("midResetStatus", {29'd0, status}, 32'd0);
        checkOutput("midResetRxValid", {31'd0, rx_valid}, 32'd0);
        spi_cs = 1'b1;
        waitNeg(2);
        reset = 1'b0;
        waitNeg(4);
        pushTx(8'h77);
        sendFrame(8'h12, 1'b0, cap);
        checkOutput("postResetMiso", {24'd0, cap}, 32'h77);
        checkOutput("postResetStatus", {29'd0, status}, 32'd0);
        drain("postResetDrain");

        waitNeg(10);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
